// File: rtl/axi_slave_regfile.sv
// AXI4-Lite slave register file.
// Writes: independent one-deep AW and W buffers that commit together.
// Reads: one outstanding request, captured one edge after the AR handshake.
// RO_MASK marks registers whose read value comes from ro_in instead of storage.
module axi_slave_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           s_axi_awaddr,
    input  logic [2:0]                              s_axi_awprot,
    input  logic                                    s_axi_awvalid,
    output logic                                    s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         s_axi_wstrb,
    input  logic                                    s_axi_wvalid,
    output logic                                    s_axi_wready,
    output logic [1:0]                              s_axi_bresp,
    output logic                                    s_axi_bvalid,
    input  logic                                    s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           s_axi_araddr,
    input  logic [2:0]                              s_axi_arprot,
    input  logic                                    s_axi_arvalid,
    output logic                                    s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           s_axi_rdata,
    output logic [1:0]                              s_axi_rresp,
    output logic                                    s_axi_rvalid,
    input  logic                                    s_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]  reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]  ro_in
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write side state
    logic                  r_aw_full;
    logic [IDX_W-1:0]      r_aw_idx;
    logic                  r_awready;
    logic                  r_w_full;
    logic [DW-1:0]         r_wdata;
    logic [DW/8-1:0]       r_wstrb;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [DW-1:0]         r_regs [NUM_REGS];

    // Read side state
    logic                  r_ar_pend;
    logic [IDX_W-1:0]      r_ar_idx;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DW-1:0]         r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic                  w_aw_full_nxt;
    logic                  w_w_full_nxt;
    logic                  w_aw_in_range;
    logic [SEL_W-1:0]      w_aw_sel;
    logic                  w_wr_ok;
    logic [DW-1:0]         w_bmask;
    logic                  w_ar_hs;
    logic                  w_ar_in_range;
    logic [SEL_W-1:0]      w_ar_sel;
    logic [DW-1:0]         w_rd_data;
    logic [DW-1:0]         w_ro [NUM_REGS];
    logic                  w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    assign w_aw_hs       = s_axi_awvalid & r_awready;
    assign w_w_hs        = s_axi_wvalid & r_wready;
    assign w_commit      = r_aw_full & r_w_full & ~r_bvalid;
    assign w_aw_full_nxt = (r_aw_full & ~w_commit) | w_aw_hs;
    assign w_w_full_nxt  = (r_w_full & ~w_commit) | w_w_hs;
    assign w_aw_in_range = (r_aw_idx < IDX_LIMIT);
    assign w_aw_sel      = r_aw_idx[SEL_W-1:0];
    assign w_wr_ok       = w_aw_in_range & ~RO_MASK[w_aw_sel];

    assign w_ar_hs       = s_axi_arvalid & r_arready;
    assign w_ar_in_range = (r_ar_idx < IDX_LIMIT);
    assign w_ar_sel      = r_ar_idx[SEL_W-1:0];

    // Ready flags are the registered complement of the next buffer occupancy
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_awready <= 1'b0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wready  <= 1'b0;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_awready <= ~w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_wready  <= ~w_w_full_nxt;
            if (w_aw_hs) r_aw_idx <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
        end
    end

    // Write response: raised on commit, held until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bvalid <= 1'b0;
            r_bresp  <= '0;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_bvalid && s_axi_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    for (genvar b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin : g_bmask
        assign w_bmask[b*8 +: 8] = {8{r_wstrb[b]}};
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic w_we;
        assign w_we = w_commit & w_wr_ok & (w_aw_sel == SEL_W'(g));

        // Byte-lane masked update of register g on a committed write
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)  r_regs[g] <= '0;
            else if (w_we) r_regs[g] <= (r_regs[g] & ~w_bmask) | (s_axi_wdata_mux(g));
        end

        assign w_ro[g]             = ro_in[g*DW +: DW];
        assign reg_out[g*DW +: DW] = RO_MASK[g] ? '0 : r_regs[g];
    end

    function automatic logic [DW-1:0] s_axi_wdata_mux(input int unsigned idx);
        s_axi_wdata_mux = (idx < NUM_REGS) ? (r_wdata & w_bmask) : '0;
    endfunction

    // Read data source for the captured address
    always_comb begin
        w_rd_data = '0;
        if (w_ar_in_range) begin
            w_rd_data = RO_MASK[w_ar_sel] ? w_ro[w_ar_sel] : r_regs[w_ar_sel];
        end
    end

    // Read channel: AR latched at the handshake edge, data captured on the next edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ar_pend <= 1'b0;
            r_ar_idx  <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
        end else if (w_ar_hs) begin
            r_ar_pend <= 1'b1;
            r_ar_idx  <= s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            r_arready <= 1'b0;
        end else if (r_ar_pend) begin
            r_ar_pend <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid) begin
            if (s_axi_rready) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end
        end else begin
            r_arready <= 1'b1;
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_slave_regfile.sv
// Scoreboard bench for axi_slave_regfile: stimulus pushes expected B/R
// responses into queues, a monitor pops and compares on each handshake.
module tb_axi_slave_regfile;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [AW-1:0]     s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DW-1:0]     s_axi_wdata;
    logic [DW/8-1:0]   s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [AW-1:0]     s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  ro_in;

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [31:0] mdl [NR];
    logic [1:0]  m_b;
    logic [33:0] m_r;

    always #5 aclk = ~aclk;

    axi_slave_regfile #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR),
        .RO_MASK(8'h01)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_out(reg_out), .ro_in(ro_in)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s reg_out[%0d]", tag, i), 64'(reg_out[i*DW +: DW]), 64'(mdl[i]));
    endtask

    // Monitor: compare every accepted response against the scoreboard
    always @(negedge aclk) begin
        if (aresetn && s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected: got bresp %b with no write outstanding", s_axi_bresp);
            end else begin
                m_b = exp_b.pop_front();
                check("bresp", 64'(s_axi_bresp), 64'(m_b));
            end
        end
        if (aresetn && s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected: got rdata 0x%0h with no read outstanding", s_axi_rdata);
            end else begin
                m_r = exp_r.pop_front();
                check("rdata", 64'(s_axi_rdata), 64'(m_r[33:2]));
                check("rresp", 64'(s_axi_rresp), 64'(m_r[1:0]));
            end
        end
    end

    // Issue one write; W is offered first and AW after aw_delay cycles
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input int aw_delay);
        int   n = 0;
        logic aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs;
        exp_b.push_back(resp);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_wvalid = 1'b1;
        if (aw_delay == 0) s_axi_awvalid = 1'b1;
        while ((aw_pend || w_pend) && n < 40) begin
            @(negedge aclk);
            aw_hs = s_axi_awvalid & s_axi_awready;
            w_hs  = s_axi_wvalid & s_axi_wready;
            @(posedge aclk); #1;
            n++;
            if (aw_hs) begin s_axi_awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_hs)  begin s_axi_wvalid = 1'b0; w_pend = 1'b0; end
            if (w_hs && aw_pend) check("w_buffered_wready", 64'(s_axi_wready), 64'd0);
            if (aw_pend && !s_axi_awvalid && n >= aw_delay) s_axi_awvalid = 1'b1;
        end
        if (aw_pend || w_pend) begin
            checks++; failures++;
            $display("FAIL write_timeout: got no handshake for addr 0x%0h within 40 cycles", addr);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int   n = 0;
        logic hs = 1'b0;
        exp_r.push_back({data, resp});
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (!hs && n < 40) begin
            @(negedge aclk);
            hs = s_axi_arready;
            @(posedge aclk); #1;
            n++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) begin
            checks++; failures++;
            $display("FAIL read_timeout: got no AR handshake for addr 0x%0h within 40 cycles", addr);
        end else begin
            check("r_not_early", 64'(s_axi_rvalid), 64'd0);
            @(posedge aclk); #1;
            check("r_latency", 64'(s_axi_rvalid), 64'd1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            checks++; failures++;
            $display("FAIL idle_timeout: got %0d B and %0d R pending, expected 0", exp_b.size(), exp_r.size());
        end
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, " awready"}, 64'(s_axi_awready), 64'd0);
        check({tag, " wready"},  64'(s_axi_wready),  64'd0);
        check({tag, " arready"}, 64'(s_axi_arready), 64'd0);
        check({tag, " bvalid"},  64'(s_axi_bvalid),  64'd0);
        check({tag, " rvalid"},  64'(s_axi_rvalid),  64'd0);
        check({tag, " bresp"},   64'(s_axi_bresp),   64'd0);
        check({tag, " rresp"},   64'(s_axi_rresp),   64'd0);
        check({tag, " rdata"},   64'(s_axi_rdata),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ro_in = '0;
        ro_in[31:0]  = 32'hCAFE_0001;
        ro_in[63:32] = 32'h5555_AAAA;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        #2;
        check_outputs_clear("reset");
        check_regs("reset");
        #19 aresetn = 1'b1;
        @(posedge aclk); #1;
        check("post_reset awready", 64'(s_axi_awready), 64'd1);
        check("post_reset wready",  64'(s_axi_wready),  64'd1);
        check("post_reset arready", 64'(s_axi_arready), 64'd1);

        // Same-cycle AW/W to reg 2, one-cycle response latency
        do_write(32'h0000_0008, 32'hA5A5_A5A5, 4'hF, OKAY, 0);
        check("t1 b_not_early", 64'(s_axi_bvalid), 64'd0);
        @(posedge aclk); #1;
        check("t1 b_latency", 64'(s_axi_bvalid), 64'd1);
        mdl[2] = 32'hA5A5_A5A5;
        check_regs("t1");
        do_read(32'h0000_0008, 32'hA5A5_A5A5, OKAY);
        do_read(32'h0000_000B, 32'hA5A5_A5A5, OKAY);
        wait_idle();

        // W leads AW by three cycles, partial strobe
        do_write(32'h0000_0004, 32'hFFFF_FFFF, 4'hF, OKAY, 0);
        mdl[1] = 32'hFFFF_FFFF;
        wait_idle();
        do_write(32'h0000_0004, 32'h1234_5678, 4'h3, OKAY, 3);
        @(posedge aclk); #1;
        mdl[1] = 32'hFFFF_5678;
        check_regs("t2");
        do_read(32'h0000_0004, 32'hFFFF_5678, OKAY);
        wait_idle();

        // Zero strobe, out-of-range write and read
        do_write(32'h0000_000C, 32'hFFFF_FFFF, 4'h0, OKAY, 0);
        do_write(32'h0000_0020, 32'hDEAD_BEEF, 4'hF, SLVERR, 0);
        wait_idle();
        check_regs("t3");
        do_read(32'h0000_0020, 32'h0000_0000, SLVERR);
        do_read(32'h0000_001C, 32'h0000_0000, OKAY);
        wait_idle();

        // Read-only register 0
        do_write(32'h0000_0000, 32'h1234_5678, 4'hF, SLVERR, 0);
        do_read(32'h0000_0000, 32'hCAFE_0001, OKAY);
        wait_idle();
        check_regs("t4");

        // Read and commit to the same register at the same edge
        fork
            do_write(32'h0000_0008, 32'h0F0F_0F0F, 4'hF, OKAY, 0);
            do_read(32'h0000_0008, 32'hA5A5_A5A5, OKAY);
        join
        wait_idle();
        mdl[2] = 32'h0F0F_0F0F;
        check_regs("t5");
        do_read(32'h0000_0008, 32'h0F0F_0F0F, OKAY);
        wait_idle();

        // B backpressure with a second write buffered behind it
        s_axi_bready = 1'b0;
        do_write(32'h0000_0010, 32'h1111_1111, 4'hF, OKAY, 0);
        mdl[4] = 32'h1111_1111;
        repeat (5) begin @(posedge aclk); #1; end
        check("t6 bvalid_held", 64'(s_axi_bvalid), 64'd1);
        do_write(32'h0000_0014, 32'h2222_2222, 4'hF, OKAY, 0);
        repeat (2) begin
            @(posedge aclk); #1;
            check("t6 awready_bp", 64'(s_axi_awready), 64'd0);
            check("t6 wready_bp",  64'(s_axi_wready),  64'd0);
        end
        check_regs("t6 held");
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        check("t6 bvalid_gap", 64'(s_axi_bvalid), 64'd0);
        check_regs("t6 gap");
        @(posedge aclk); #1;
        check("t6 second_b", 64'(s_axi_bvalid), 64'd1);
        check("t6 awready_free", 64'(s_axi_awready), 64'd1);
        mdl[5] = 32'h2222_2222;
        check_regs("t6 commit");
        wait_idle();

        // Asynchronous reset while B and R are both pending
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        do_write(32'h0000_0018, 32'h3333_3333, 4'hF, OKAY, 0);
        do_read(32'h0000_0008, 32'h0F0F_0F0F, OKAY);
        check("t7 bvalid_pending", 64'(s_axi_bvalid), 64'd1);
        s_axi_awaddr = 32'h0000_001C; s_axi_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        #3 aresetn = 1'b0;
        #1;
        check_outputs_clear("t7");
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        check_regs("t7");
        exp_b.delete(); exp_r.delete();
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        #8 aresetn = 1'b1;
        @(posedge aclk); #1;
        check("t7 awready_back", 64'(s_axi_awready), 64'd1);
        check("t7 arready_back", 64'(s_axi_arready), 64'd1);
        s_axi_wdata = 32'h9999_0000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
        repeat (4) begin @(posedge aclk); #1; end
        check("t7 no_late_b", 64'(s_axi_bvalid), 64'd0);
        check("t7 no_late_r", 64'(s_axi_rvalid), 64'd0);
        check_regs("t7 idle");
        exp_b.push_back(OKAY);
        s_axi_awaddr = 32'h0000_000C; s_axi_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        @(posedge aclk); #1;
        mdl[3] = 32'h9999_0000;
        check_regs("t7 resume");
        wait_idle();
        do_read(32'h0000_000C, 32'h9999_0000, OKAY);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
